// File: rtl/key_debounce_multi.sv
// key_debounce_multi -- N-channel push-button conditioner.
//
// Each channel takes one raw, asynchronous key level and produces:
//   - a debounced level (same polarity as the raw input),
//   - registered 1-cycle pulses on debounced rising and falling edges,
//   - a 1-cycle long-press pulse LONG_CYCLES after the press is accepted,
//   - 1-cycle auto-repeat pulses every REPEAT_CYCLES after the long press
//     (REPEAT_CYCLES = 0 keeps a held key silent after the long pulse).
// Channels are fully independent; they only share clk and rst.
//
// Ports (top):
//   clk             in   1          system clock
//   rst             in   1          synchronous, active-high reset
//   button_in       in   NUM_KEYS   raw key levels
//   button_out      out  NUM_KEYS   debounced levels
//   button_posedge  out  NUM_KEYS   pulse when button_out rises 0->1
//   button_negedge  out  NUM_KEYS   pulse when button_out falls 1->0
//   button_long     out  NUM_KEYS   long-press pulse
//   button_repeat   out  NUM_KEYS   auto-repeat pulse

// ---------------------------------------------------------------------------
// Per-channel lane: synchroniser, debounce counter, edge pulses, hold FSM.
// ---------------------------------------------------------------------------
module key_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000,
  parameter bit IDLE_LVL        = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_out,
  output logic pos_pulse,
  output logic neg_pulse,
  output logic long_pulse,
  output logic rep_pulse
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  // A zero repeat period still needs a 1-bit counter to keep the code legal.
  localparam int REP_W  = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;
  localparam bit REP_EN = (REPEAT_CYCLES != 0);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Synchroniser + debounce
  // -------------------------------------------------------------------------
  logic            s1, s2;
  logic [DB_W-1:0] db_cnt;
  logic            accept, press_acc, rel_acc;

  // The debounced level flips on the same edge in which accept is high, so
  // the hold FSM can react to press/release in lock-step with the edge pulse.
  assign accept    = (s2 != key_out) && (db_cnt == DB_LAST);
  assign press_acc = accept && (s2 != IDLE_LVL);
  assign rel_acc   = accept && (s2 == IDLE_LVL);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= IDLE_LVL;
      s2        <= IDLE_LVL;
      key_out   <= IDLE_LVL;
      db_cnt    <= '0;
      pos_pulse <= 1'b0;
      neg_pulse <= 1'b0;
    end else begin
      s1        <= key_in;
      s2        <= s1;
      pos_pulse <= 1'b0;
      neg_pulse <= 1'b0;
      if (s2 == key_out) begin
        // Any return to the current level restarts the stability window.
        db_cnt <= '0;
      end else if (accept) begin
        key_out   <= s2;
        db_cnt    <= '0;
        pos_pulse <= s2;
        neg_pulse <= ~s2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Hold FSM: long press and auto-repeat
  // -------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [REP_W-1:0]    rep_q, rep_d;
  logic                long_d, rep_pulse_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      rep_q      <= '0;
      long_pulse <= 1'b0;
      rep_pulse  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      rep_q      <= rep_d;
      long_pulse <= long_d;
      rep_pulse  <= rep_pulse_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    rep_d       = rep_q;
    long_d      = 1'b0;
    rep_pulse_d = 1'b0;
    if (rel_acc) begin
      // Release takes priority: a long/repeat pulse due this cycle is dropped.
      state_d = ST_IDLE;
      hold_d  = '0;
      rep_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (press_acc) begin
            state_d = ST_HELD;
            hold_d  = HOLD_W'(1);
          end
        end
        ST_HELD: begin
          // hold_q equals the number of cycles since the accept edge.
          if (hold_q == HOLD_LAST) begin
            long_d  = 1'b1;
            state_d = ST_LONG;
            hold_d  = '0;
            rep_d   = REP_W'(1);
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        ST_LONG: begin
          if (REP_EN) begin
            if (rep_q == REP_LAST) begin
              rep_pulse_d = 1'b1;
              rep_d       = REP_W'(1);
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          hold_d  = '0;
          rep_d   = '0;
        end
      endcase
    end
  end

endmodule

// ---------------------------------------------------------------------------
// Top: one lane per key.
// ---------------------------------------------------------------------------
module key_debounce_multi #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] button_in,
  output logic [NUM_KEYS-1:0] button_out,
  output logic [NUM_KEYS-1:0] button_posedge,
  output logic [NUM_KEYS-1:0] button_negedge,
  output logic [NUM_KEYS-1:0] button_long,
  output logic [NUM_KEYS-1:0] button_repeat
);

  // Idle level equals ACTIVE_LOW: active-low keys idle high.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
    key_debounce_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .IDLE_LVL        (ACTIVE_LOW)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .key_in     (button_in[i]),
      .key_out    (button_out[i]),
      .pos_pulse  (button_posedge[i]),
      .neg_pulse  (button_negedge[i]),
      .long_pulse (button_long[i]),
      .rep_pulse  (button_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi (2 keys, debounce 8, long 40,
// repeat 10, active low) plus a second instance with repeat disabled.
// Stimulus pushes expected pulse events (cycle, kind, channel); a monitor
// pops one event for every pulse the DUT raises and flags extra/missing ones.
module tb_key_debounce_multi;
  localparam int NK = 2;
  localparam int D  = 8;
  localparam int L  = 40;
  localparam int R  = 10;

  localparam int K_NEG  = 0;
  localparam int K_POS  = 1;
  localparam int K_LONG = 2;
  localparam int K_REP  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] button_in = 2'b11;
  logic [NK-1:0] button_out, button_posedge, button_negedge, button_long, button_repeat;
  logic [NK-1:0] nr_in = 2'b11;
  logic [NK-1:0] nr_out, nr_pos, nr_neg, nr_long, nr_rep;

  key_debounce_multi #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L),
                       .REPEAT_CYCLES(R), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .button_in(button_in), .button_out(button_out),
    .button_posedge(button_posedge), .button_negedge(button_negedge),
    .button_long(button_long), .button_repeat(button_repeat));

  key_debounce_multi #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L),
                       .REPEAT_CYCLES(0), .ACTIVE_LOW(1'b1)) dut_nr (
    .clk(clk), .rst(rst), .button_in(nr_in), .button_out(nr_out),
    .button_posedge(nr_pos), .button_negedge(nr_neg),
    .button_long(nr_long), .button_repeat(nr_rep));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; int k; int ch; } ev_t;
  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  int  nr_long_cnt = 0;
  int  nr_rep_cnt  = 0;
  int  nr_long_cyc = -1;

  task automatic push(input int c, input int k, input int ch);
    ev_t e;
    e.c = c; e.k = k; e.ch = ch;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard monitor for the main DUT.
  always @(negedge clk) begin
    logic [3:0][NK-1:0] p;
    ev_t e;
    if (mon_en) begin
      p[K_NEG]  = button_negedge;
      p[K_POS]  = button_posedge;
      p[K_LONG] = button_long;
      p[K_REP]  = button_repeat;
      for (int k = 0; k < 4; k++) begin
        for (int ch = 0; ch < NK; ch++) begin
          if (p[k][ch] !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL pulse: got kind %0d ch %0d at cyc %0d, expected no pulse", k, ch, cyc);
            end else begin
              e = exp_q.pop_front();
              if (e.c != cyc || e.k != k || e.ch != ch) begin
                errors++;
                $display("FAIL pulse: got kind %0d ch %0d cyc %0d, expected kind %0d ch %0d cyc %0d",
                         k, ch, cyc, e.k, e.ch, e.c);
              end
            end
          end
        end
      end
      if (exp_q.size() > 0 && exp_q[0].c < cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_pulse: got none, expected kind %0d ch %0d at cyc %0d", e.k, e.ch, e.c);
      end
    end
  end

  // Counter for the repeat-disabled instance.
  always @(negedge clk) begin
    if (mon_en) begin
      if (nr_long[0] === 1'b1) begin
        nr_long_cnt++;
        nr_long_cyc = cyc;
      end
      if (nr_rep !== 2'b00) nr_rep_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time (cyc %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int c, t, t0;
    // 1: reset held 5 cycles, outputs idle during and after.
    @(negedge clk);
    mon_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_out", int'(button_out), 3);
    chk("reset_nr_out", int'(nr_out), 3);
    rst = 1'b0;
    goto(cyc + 20);
    chk("post_reset_out", int'(button_out), 3);

    // 2: bounce shorter than the debounce window never gets through.
    for (int i = 0; i < 6; i++) begin
      button_in[0] = 1'b0; goto(cyc + 5);
      button_in[0] = 1'b1; goto(cyc + 3);
    end
    goto(cyc + 20);
    chk("bounce_out", int'(button_out), 3);

    // 3: clean press/release latency is exactly 2+D cycles.
    c = cyc;
    button_in[0] = 1'b0;
    push(c + 10, K_NEG, 0);
    goto(c + 9);  chk("press_c9", int'(button_out[0]), 1);
    goto(c + 10); chk("press_c10", int'(button_out[0]), 0);
    goto(c + 20);
    c = cyc;
    button_in[0] = 1'b1;
    push(c + 10, K_POS, 0);
    goto(c + 9);  chk("release_r9", int'(button_out[0]), 0);
    goto(c + 10); chk("release_r10", int'(button_out[0]), 1);
    goto(c + 30);

    // 4: long press with repeats, release stops them.
    c = cyc; t = c + 10;
    button_in[0] = 1'b0;
    push(t, K_NEG, 0);
    push(t + 40, K_LONG, 0);
    for (int k = 1; k <= 5; k++) push(t + 40 + k * 10, K_REP, 0);
    push(t + 95, K_POS, 0);
    goto(t + 85);
    button_in[0] = 1'b1;
    goto(t + 120);
    chk("hold_out", int'(button_out), 3);

    // 4b: release accepted exactly when the long pulse is due suppresses it.
    c = cyc; t = c + 10;
    button_in[0] = 1'b0;
    push(t, K_NEG, 0);
    push(t + 40, K_POS, 0);
    goto(t + 30);
    button_in[0] = 1'b1;
    goto(t + 70);

    // 4c: release accepted when a repeat is due suppresses that repeat.
    c = cyc; t = c + 10;
    button_in[0] = 1'b0;
    push(t, K_NEG, 0);
    push(t + 40, K_LONG, 0);
    push(t + 50, K_REP, 0);
    push(t + 60, K_POS, 0);
    goto(t + 50);
    button_in[0] = 1'b1;
    goto(t + 90);

    // 5: two channels offset by 3 cycles, reset mid-hold.
    c = cyc; t0 = c + 10;
    button_in[0] = 1'b0;
    push(t0, K_NEG, 0);
    push(t0 + 3, K_NEG, 1);
    push(t0 + 40, K_LONG, 0);
    push(t0 + 43, K_LONG, 1);
    goto(c + 3);
    button_in[1] = 1'b0;
    goto(t0 + 44);
    rst = 1'b1;
    button_in = 2'b11;
    goto(t0 + 45);
    chk("midhold_reset_out", int'(button_out), 3);
    goto(t0 + 47);
    rst = 1'b0;
    goto(cyc + 25);
    chk("after_reset_out", int'(button_out), 3);

    // 6: repeat disabled -> one long pulse, no repeats.
    c = cyc; t = c + 10;
    nr_in[0] = 1'b0;
    goto(t + 100);
    nr_in[0] = 1'b1;
    goto(t + 130);
    chk("nr_long_count", nr_long_cnt, 1);
    chk("nr_long_cycle", nr_long_cyc, t + 40);
    chk("nr_repeat_count", nr_rep_cnt, 0);
    chk("nr_out", int'(nr_out), 3);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
